// File: rtl/mac_share_arb_pkg.sv
// Shared defaults and FSM encoding for the shared multiply-add arbiter.
// Optional stats build: MAC_SHARE_ARB_STATS_EN.
package mac_share_arb_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_W_IN       = 8;
  localparam int DEF_W_OUT      = 16;
  localparam int DEF_LAT        = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

endpackage

// File: rtl/mac_share_arb_if.sv
// Requester operand bus and result stream of the shared MAC.
// The arbiter takes the slave side; the producers/consumer take master.
interface mac_share_arb_if
  import mac_share_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W_IN  = DEF_W_IN,
  parameter int W_OUT = DEF_W_OUT
) ();

  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*W_IN-1:0] req_a;
  logic [N_REQ*W_IN-1:0] req_b;
  logic [N_REQ*W_IN-1:0] req_c;
  logic                  res_valid;
  logic [W_OUT-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_ready;

  modport master (
    output req_valid, req_a, req_b, req_c,
    output res_ready,
    input  req_ready,
    input  res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c,
    input  res_ready,
    output req_ready,
    output res_valid, res_data, res_id
  );

endinterface

// File: rtl/mac_share_arb_mac_pipe.sv
// Pipelined unsigned a*b+c, LAT register stages, id/valid ride along.
// No flow control: the arbiter's credits guarantee downstream space.
module mac_pipe
  import mac_share_arb_pkg::*;
#(
  parameter int W_IN  = DEF_W_IN,
  parameter int W_OUT = DEF_W_OUT,
  parameter int LAT   = DEF_LAT,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W_IN-1:0]  a,
  input  logic [W_IN-1:0]  b,
  input  logic [W_IN-1:0]  c,
  input  logic [IDW-1:0]   in_id,
  output logic             out_valid,
  output logic [W_OUT-1:0] out_data,
  output logic [IDW-1:0]   out_id
);

  localparam int PW = 2 * W_IN;
  localparam int SW = ((PW > W_OUT) ? PW : W_OUT) + 1;

  logic [SW-1:0] sum;

  logic             v_q  [LAT];
  logic [W_OUT-1:0] d_q  [LAT];
  logic [IDW-1:0]   id_q [LAT];

  // wide enough for the full product plus carry, then truncated
  assign sum = SW'(a) * SW'(b) + SW'(c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        v_q[s]  <= 1'b0;
        d_q[s]  <= '0;
        id_q[s] <= '0;
      end
    end else begin
      v_q[0]  <= in_valid;
      d_q[0]  <= sum[W_OUT-1:0];
      id_q[0] <= in_id;
      for (int s = 1; s < LAT; s++) begin
        v_q[s]  <= v_q[s-1];
        d_q[s]  <= d_q[s-1];
        id_q[s] <= id_q[s-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_data  = d_q[LAT-1];
  assign out_id    = id_q[LAT-1];

endmodule

// File: rtl/mac_share_arb.sv
// Round-robin sharing of one pipelined MAC with a credited result FIFO.
// Define MAC_SHARE_ARB_STATS_EN to add per-requester grant counters.
module mac_share_arb
  import mac_share_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int W_IN       = DEF_W_IN,
  parameter int W_OUT      = DEF_W_OUT,
  parameter int LAT        = DEF_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  mac_share_arb_if.slave bus,
  output logic busy
`ifdef MAC_SHARE_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] grant_cnt
`endif
);

  localparam int IDW = $clog2(N_REQ);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  state_t state;
  state_t state_nxt;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           found;
  logic           any_req;
  logic           credit;
  logic           issue;

  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic [CW:0]   limit;

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [W_OUT-1:0] mem    [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id [FIFO_DEPTH];
  logic [W_OUT-1:0] last_data;
  logic [IDW-1:0]   last_id;
  logic [W_OUT-1:0] head_data;
  logic [IDW-1:0]   head_id;
  logic             empty;
  logic             push;
  logic             pop;

  logic [W_IN-1:0]  op_a;
  logic [W_IN-1:0]  op_b;
  logic [W_IN-1:0]  op_c;
  logic             p_valid;
  logic [W_OUT-1:0] p_data;
  logic [IDW-1:0]   p_id;

  assign any_req = |bus.req_valid;
  assign busy    = (inflight != '0) || (count != '0);

  // round-robin scan starting at ptr
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // a same-cycle pop frees the slot it vacates
  assign used   = {1'b0, inflight} + {1'b0, count};
  assign limit  = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign credit = used < limit;

  assign issue = en && credit && found &&
                 ((state == RUN) || (state == IDLE));

  assign bus.req_ready =
    issue ? (N_REQ'(1) << gnt_idx) : '0;

  assign ptr_nxt = (gnt_idx == IDW'(N_REQ - 1)) ?
                   '0 : gnt_idx + IDW'(1);

  assign op_a = bus.req_a[gnt_idx*W_IN +: W_IN];
  assign op_b = bus.req_b[gnt_idx*W_IN +: W_IN];
  assign op_c = bus.req_c[gnt_idx*W_IN +: W_IN];

  mac_pipe #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT),
    .LAT   (LAT),
    .IDW   (IDW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .a         (op_a),
    .b         (op_b),
    .c         (op_c),
    .in_id     (gnt_idx),
    .out_valid (p_valid),
    .out_data  (p_data),
    .out_id    (p_id)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en && any_req) state_nxt = RUN;
      end
      RUN: begin
        if (!en) state_nxt = DRAIN;
        else if (!any_req && !busy) state_nxt = IDLE;
      end
      DRAIN: begin
        if (en) state_nxt = RUN;
        else if (!busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (issue) ptr <= ptr_nxt;
    end
  end

  // fall-through head: an arriving result is visible in its push cycle
  assign push  = p_valid;
  assign empty = (count == '0);
  assign pop   = bus.res_valid && bus.res_ready;

  assign bus.res_valid = !empty || push;

  always_comb begin
    head_data = last_data;
    head_id   = last_id;
    if (!empty) begin
      head_data = mem[rd_ptr];
      head_id   = mem_id[rd_ptr];
    end else if (push) begin
      head_data = p_data;
      head_id   = p_id;
    end
  end

  assign bus.res_data = head_data;
  assign bus.res_id   = head_id;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]    <= p_data;
      mem_id[wr_ptr] <= p_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      last_data <= '0;
      last_id   <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(push);
      count    <= count + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ?
                  '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ?
                     '0 : rd_ptr + AW'(1);
        last_data <= head_data;
        last_id   <= head_id;
      end
    end
  end

`ifdef MAC_SHARE_ARB_STATS_EN
  logic [15:0] cnt [N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i] &&
            cnt[i] != 16'hFFFF) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_mac_share_arb.sv
// Directed bench for mac_share_arb: vector table plus multi-cycle cases.
module tb_mac_share_arb;
  import mac_share_arb_pkg::*;

  localparam int N   = 4;
  localparam int WI  = 8;
  localparam int LAT = 2;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic busy;
  logic busy8;

  always #5 clk = ~clk;

  mac_share_arb_if #(.N_REQ(N), .W_IN(WI), .W_OUT(16)) bus ();
  mac_share_arb_if #(.N_REQ(N), .W_IN(WI), .W_OUT(8))  bus8 ();

  assign bus8.req_valid = bus.req_valid;
  assign bus8.req_a     = bus.req_a;
  assign bus8.req_b     = bus.req_b;
  assign bus8.req_c     = bus.req_c;
  assign bus8.res_ready = bus.res_ready;

`ifdef MAC_SHARE_ARB_STATS_EN
  logic [N*16-1:0] gc;
  logic [N*16-1:0] gc8;
`endif

  mac_share_arb #(
    .N_REQ(N), .W_IN(WI), .W_OUT(16),
    .LAT(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (bus),
    .busy (busy)
`ifdef MAC_SHARE_ARB_STATS_EN
    ,
    .grant_cnt (gc)
`endif
  );

  mac_share_arb #(
    .N_REQ(N), .W_IN(WI), .W_OUT(8),
    .LAT(LAT), .FIFO_DEPTH(FD)
  ) dut8 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (bus8),
    .busy (busy8)
`ifdef MAC_SHARE_ARB_STATS_EN
    ,
    .grant_cnt (gc8)
`endif
  );

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [15:0] e16;
    logic [7:0]  e8;
  } vec_t;

  vec_t vt [5];

  int total = 0;
  int bad   = 0;
  int ngr;
  int nres;
  bit seen;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en  = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic set_all;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*WI +: WI] = 8'(i + 1);
      bus.req_b[i*WI +: WI] = 8'd2;
      bus.req_c[i*WI +: WI] = 8'd0;
    end
    bus.req_valid = '1;
  endtask

  initial begin
    vt[0] = '{0, 8'd3,   8'd4,   8'd5,   16'd17,    8'd17};
    vt[1] = '{1, 8'd255, 8'd255, 8'd255, 16'hFF00,  8'h00};
    vt[2] = '{2, 8'd0,   8'd0,   8'd0,   16'd0,     8'd0};
    vt[3] = '{3, 8'd16,  8'd16,  8'd1,   16'd257,   8'd1};
    vt[4] = '{2, 8'd200, 8'd100, 8'd50,  16'h4E52,  8'h52};

    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    en  = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst ready", bus.req_ready, 0);
    chk("rst rvalid", bus.res_valid, 0);
    chk("rst data", bus.res_data, 0);
    chk("rst id", bus.res_id, 0);
    chk("rst busy", busy, 0);
    do_reset;

    // single requests, including wrap cases
    for (int v = 0; v < 5; v++) begin
      bus.req_valid = '0;
      bus.req_valid[vt[v].id] = 1'b1;
      bus.req_a[vt[v].id*WI +: WI] = vt[v].a;
      bus.req_b[vt[v].id*WI +: WI] = vt[v].b;
      bus.req_c[vt[v].id*WI +: WI] = vt[v].c;
      en = 1'b1;
      #1;
      chk("vec grant", bus.req_ready, 1 << vt[v].id);
      step;
      bus.req_valid = '0;
      for (int k = 1; k < LAT; k++) begin
        chk("vec early", bus.res_valid, 0);
        step;
      end
      chk("vec valid", bus.res_valid, 1);
      chk("vec data16", bus.res_data, vt[v].e16);
      chk("vec data8", bus8.res_data, vt[v].e8);
      chk("vec id", bus.res_id, vt[v].id);
      step;
      chk("vec empty", bus.res_valid, 0);
      chk("vec hold", bus.res_data, vt[v].e16);
    end

    // all requesters continuously valid
    do_reset;
    set_all;
    en = 1'b1;
    nres = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 8) bus.req_valid = '0;
      #1;
      if (k < 8) chk("rr grant", bus.req_ready, 1 << (k % 4));
      if (bus.res_valid) begin
        chk("rr data", bus.res_data, 2 * (nres % 4 + 1));
        chk("rr id", bus.res_id, nres % 4);
        nres++;
      end
      step;
    end
    chk("rr count", nres, 8);

    // backpressure fills the credits, then refill on pops
    do_reset;
    set_all;
    bus.res_ready = 1'b0;
    en = 1'b1;
    ngr = 0;
    nres = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (|bus.req_ready) begin
        chk("bp grant", bus.req_ready, 1 << (ngr % 4));
        ngr++;
      end
      step;
    end
    #1;
    chk("bp grants", ngr, 4);
    chk("bp stall", bus.req_ready, 0);
    chk("bp head", bus.res_valid, 1);
    chk("bp hdata", bus.res_data, 2);
    chk("bp busy", busy, 1);
    step;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("bp refill", bus.req_ready, 1 << (ngr % 4));
      ngr++;
      chk("bp rvalid", bus.res_valid, 1);
      chk("bp rdata", bus.res_data, 2 * (nres % 4 + 1));
      chk("bp rid", bus.res_id, nres % 4);
      nres++;
      step;
    end
    bus.req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.res_valid) begin
        chk("bp ddata", bus.res_data, 2 * (nres % 4 + 1));
        nres++;
      end
      step;
    end
    chk("bp nolost", nres, 16);
    chk("bp idle", busy, 0);

    // en dropped after two grants
    do_reset;
    set_all;
    en = 1'b1;
    #1;
    chk("en g0", bus.req_ready, 1);
    step;
    chk("en g1", bus.req_ready, 2);
    step;
    en = 1'b0;
    seen = 1'b0;
    nres = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (|bus.req_ready) seen = 1'b1;
      if (bus.res_valid) begin
        chk("en data", bus.res_data, 2 * (nres + 1));
        chk("en id", bus.res_id, nres);
        nres++;
      end
      if (!busy) break;
      step;
    end
    chk("en nogrant", seen, 0);
    chk("en results", nres, 2);
    chk("en busy", busy, 0);
    step;
    chk("en state", dut.state, IDLE);

    // reset with two ops in flight
    do_reset;
    set_all;
    en = 1'b1;
    step;
    step;
    bus.req_valid = '0;
    #1;
    chk("rr pre", bus.res_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid rvalid", bus.res_valid, 0);
    chk("mid data", bus.res_data, 0);
    chk("mid id", bus.res_id, 0);
    chk("mid busy", busy, 0);
    chk("mid ready", bus.req_ready, 0);
    step;
    step;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.res_valid) seen = 1'b1;
      step;
    end
    chk("mid noresult", seen, 0);
    set_all;
    #1;
    chk("mid ptr0", bus.req_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
